// File: rtl/vga_timing_generator.sv
// Raster-scan timing: pixel strobe, column/row counters, blanking and sync.
// Every output is registered and updates on the rising edge of clk.
module vga_timing_generator #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       clkDiv,
  output logic [9:0] column,
  output logic [8:0] row,
  output logic       displayActive,
  output logic       hsync,
  output logic       vsync,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

  logic [DIV_W-1:0] div, div_d;
  logic [9:0]       hcount, hcount_d, vcount, vcount_d;
  logic [9:0]       h_next, v_next;
  logic             tick, line_wrap;

  logic       clk_div_d, display_active_d, hsync_d, vsync_d;
  logic       line_start_d, frame_start_d;
  logic [9:0] column_d;
  logic [8:0] row_d;

  // Counter values the next tick would produce
  always_comb begin
    tick      = (div == DIV_LAST);
    line_wrap = 1'b0;
    h_next    = hcount + 10'd1;
    v_next    = vcount;
    if (hcount == H_LAST) begin
      h_next    = '0;
      line_wrap = 1'b1;
      v_next    = (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end
  end

  // enable low folds into the synchronous next state as the reset state
  always_comb begin
    div_d            = '0;
    hcount_d         = H_LAST;
    vcount_d         = V_LAST;
    clk_div_d        = 1'b0;
    column_d         = '0;
    row_d            = '0;
    display_active_d = 1'b0;
    hsync_d          = ~SYNC_ON;
    vsync_d          = ~SYNC_ON;
    line_start_d     = 1'b0;
    frame_start_d    = 1'b0;
    if (enable) begin
      div_d            = tick ? '0 : div + DIV_W'(1);
      hcount_d         = hcount;
      vcount_d         = vcount;
      clk_div_d        = tick;
      column_d         = column;
      row_d            = row;
      display_active_d = displayActive;
      hsync_d          = hsync;
      vsync_d          = vsync;
      if (tick) begin
        hcount_d         = h_next;
        vcount_d         = v_next;
        column_d         = h_next;
        row_d            = (v_next < V_ACT) ? v_next[8:0] : '0;
        display_active_d = (h_next < H_ACT) && (v_next < V_ACT);
        hsync_d          = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d          = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ON : ~SYNC_ON;
        line_start_d     = line_wrap;
        frame_start_d    = line_wrap && (v_next == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div           <= '0;
      hcount        <= H_LAST;
      vcount        <= V_LAST;
      clkDiv        <= 1'b0;
      column        <= '0;
      row           <= '0;
      displayActive <= 1'b0;
      hsync         <= ~SYNC_ON;
      vsync         <= ~SYNC_ON;
      lineStart     <= 1'b0;
      frameStart    <= 1'b0;
    end else begin
      div           <= div_d;
      hcount        <= hcount_d;
      vcount        <= vcount_d;
      clkDiv        <= clk_div_d;
      column        <= column_d;
      row           <= row_d;
      displayActive <= display_active_d;
      hsync         <= hsync_d;
      vsync         <= vsync_d;
      lineStart     <= line_start_d;
      frameStart    <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default 640x480 instance plus a tiny CLK_DIV=1, positive-sync
// instance for whole-frame and polarity behaviour.
module tb_vga_timing_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  logic       d_cd, d_da, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_col;
  logic [8:0] d_row;
  logic       s_cd, s_da, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_col;
  logic [8:0] s_row;

  vga_timing_generator u_def (
    .clk(clk), .rst(rst), .enable(enable),
    .clkDiv(d_cd), .column(d_col), .row(d_row), .displayActive(d_da),
    .hsync(d_hs), .vsync(d_vs), .lineStart(d_ls), .frameStart(d_fs)
  );

  // 16 columns (sync 10..12) x 8 lines (sync 5..6), one pixel per clk
  vga_timing_generator #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACTIVE(1)
  ) u_small (
    .clk(clk), .rst(rst), .enable(enable),
    .clkDiv(s_cd), .column(s_col), .row(s_row), .displayActive(s_da),
    .hsync(s_hs), .vsync(s_vs), .lineStart(s_ls), .frameStart(s_fs)
  );

  logic [24:0] d_outs;
  assign d_outs = {d_cd, d_col, d_row, d_da, d_hs, d_vs, d_ls, d_fs};
  localparam logic [24:0] RST_OUTS = {1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       r, e, cd;
    logic [9:0] col;
    logic [8:0] row;
    logic       da, hs, vs, ls, fs;
  } vec_t;

  function automatic vec_t mk(input int r, e, cd, col, row, da, hs, vs, ls, fs);
    vec_t v;
    v.r = 1'(r); v.e = 1'(e); v.cd = 1'(cd);
    v.col = 10'(col); v.row = 9'(row);
    v.da = 1'(da); v.hs = 1'(hs); v.vs = 1'(vs); v.ls = 1'(ls); v.fs = 1'(fs);
    return v;
  endfunction

  vec_t vecs[10];

  int col_err, cd_err, da_cnt, da_last, hs_cnt, hs_first, hs_last, tick_n;
  int vs_cnt, row_nz, row_max, ls_cnt, fs_cnt, vs_misalign, vs_first;
  logic vs_prev;

  initial begin
    //               rst en cd col row da hs vs ls fs
    vecs[0] = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[1] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[2] = mk(0, 1, 1, 0, 0, 1, 1, 1, 1, 1);
    vecs[3] = mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    vecs[4] = mk(0, 1, 1, 1, 0, 1, 1, 1, 0, 0);
    vecs[5] = mk(0, 1, 0, 1, 0, 1, 1, 1, 0, 0);
    vecs[6] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[7] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[8] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[9] = mk(0, 1, 1, 0, 0, 1, 1, 1, 1, 1);

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].r;
      enable = vecs[i].e;
      step();
      chk($sformatf("vec%0d", i), d_outs,
          {vecs[i].cd, vecs[i].col, vecs[i].row, vecs[i].da, vecs[i].hs,
           vecs[i].vs, vecs[i].ls, vecs[i].fs});
    end

    // One full line of the default instance, starting on the frameStart tick
    col_err = 0; da_cnt = 0; da_last = -1; hs_cnt = 0;
    hs_first = -1; hs_last = -1; tick_n = 0;
    for (int c = 0; c < 1600; c++) begin
      if (c < 20) begin
        chk("strobe_cd", d_cd, (c % 2 == 0));
        chk("strobe_col", d_col, c / 2);
      end
      if (d_cd) begin
        if (int'(d_col) != tick_n) col_err++;
        if (d_da) begin da_cnt++; da_last = d_col; end
        if (!d_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = d_col;
          hs_last = d_col;
        end
        tick_n++;
      end
      step();
    end
    chk("line_ticks", tick_n, 800);
    chk("line_col_seq", col_err, 0);
    chk("da_count", da_cnt, 640);
    chk("da_last_col", da_last, 639);
    chk("hs_count", hs_cnt, 96);
    chk("hs_first_col", hs_first, 656);
    chk("hs_last_col", hs_last, 751);
    chk("wrap_col", d_col, 0);
    chk("wrap_row", d_row, 1);
    chk("wrap_ls", d_ls, 1);
    chk("wrap_fs", d_fs, 0);
    chk("wrap_cd", d_cd, 1);
    chk("wrap_da", d_da, 1);

    // Asynchronous reset in the middle of an hsync pulse
    repeat (1400) step();
    chk("mid_col", d_col, 700);
    chk("mid_hs", d_hs, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", d_outs, RST_OUTS);
    chk("async_rst_small_hs", s_hs, 0);
    chk("async_rst_small_vs", s_vs, 0);
    chk("async_rst_small_cd", s_cd, 0);
    step();
    rst = 1'b0;
    step();
    chk("rel_e1_cd", d_cd, 0);
    chk("rel_e1_da", d_da, 0);
    step();
    chk("rel_e2_fs", d_fs, 1);
    chk("rel_e2_ls", d_ls, 1);
    chk("rel_e2_da", d_da, 1);

    // enable dropped mid-line, then restored
    repeat (600) step();
    chk("en_col", d_col, 300);
    chk("en_da", d_da, 1);
    enable = 1'b0;
    step();
    chk("en_off_outs", d_outs, RST_OUTS);
    repeat (3) step();
    chk("en_hold_outs", d_outs, RST_OUTS);
    enable = 1'b1;
    step();
    chk("en_e1_cd", d_cd, 0);
    chk("en_e1_fs", d_fs, 0);
    step();
    chk("en_e2_fs", d_fs, 1);
    chk("en_e2_col", d_col, 0);
    chk("en_e2_cd", d_cd, 1);

    // Full frame of the small CLK_DIV=1, positive-polarity instance
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("small_fs", s_fs, 1);
    chk("small_ls", s_ls, 1);
    chk("small_da", s_da, 1);
    chk("small_hs_idle", s_hs, 0);
    chk("small_vs_idle", s_vs, 0);
    cd_err = 0; col_err = 0; da_cnt = 0; hs_cnt = 0; hs_first = -1;
    vs_cnt = 0; vs_first = -1; row_nz = 0; row_max = 0; ls_cnt = 0;
    fs_cnt = 0; vs_misalign = 0; vs_prev = s_vs;
    for (int c = 0; c < 128; c++) begin
      if (s_cd !== 1'b1) cd_err++;
      if (int'(s_col) != c % 16) col_err++;
      if (s_da) da_cnt++;
      if (s_hs) begin hs_cnt++; if (hs_first < 0) hs_first = c; end
      if (s_vs) begin vs_cnt++; if (vs_first < 0) vs_first = c; end
      if (s_vs !== vs_prev && s_col != 10'd0) vs_misalign++;
      vs_prev = s_vs;
      if (s_row != 9'd0) row_nz++;
      if (int'(s_row) > row_max) row_max = s_row;
      if (s_ls) ls_cnt++;
      if (s_fs && c > 0) fs_cnt++;
      step();
    end
    chk("small_cd_const", cd_err, 0);
    chk("small_col_seq", col_err, 0);
    chk("small_da_count", da_cnt, 32);
    chk("small_hs_count", hs_cnt, 24);
    chk("small_hs_first", hs_first, 10);
    chk("small_vs_count", vs_cnt, 32);
    chk("small_vs_first", vs_first, 80);
    chk("small_vs_on_wrap", vs_misalign, 0);
    chk("small_row_nonzero", row_nz, 48);
    chk("small_row_max", row_max, 3);
    chk("small_ls_count", ls_cnt, 8);
    chk("small_fs_inside", fs_cnt, 0);
    chk("small_next_fs", s_fs, 1);
    chk("small_next_col", s_col, 0);
    chk("small_next_row", s_row, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Produces the raster scan that drives every pixel-generating block in the design: the pixel-enable strobe, the pixel coordinates (column/row), displayActive, and the hsync/vsync pins for the monitor. Pixel consumers sample column/row/displayActive/clkDiv on the falling edge of clk, so this block updates all outputs on the rising edge. Default timing is 640x480 at 60 Hz, 25 MHz pixel rate derived from a 50 MHz system clock.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, logic level of hsync/vsync while asserted (0 = negative polarity)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  reset, asynchronous, active-high
enable  input  1  run enable; low holds block in reset state synchronously
clkDiv  output  1  one-clk pixel strobe, once every CLK_DIV clocks
column  output  10  horizontal pixel count 0..H_TOTAL-1
row  output  9  visible line index 0..V_ACTIVE-1; 0 during vertical blanking
displayActive  output  1  high while column<H_ACTIVE and line<V_ACTIVE
hsync  output  1  horizontal sync to monitor
vsync  output  1  vertical sync to monitor
lineStart  output  1  one-clk pulse when column becomes 0
frameStart  output  1  one-clk pulse when column and line both become 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = sum of V_* (525). Internal hcount, vcount are 10 bits.
- All state and outputs update on posedge clk; all outputs registered.
- Reset (rst high, or enable low at a posedge): divider=0, hcount=H_TOTAL-1, vcount=V_TOTAL-1; clkDiv=0, column=0, row=0, displayActive=0, hsync=vsync=!SYNC_ACTIVE, lineStart=frameStart=0.
- Divider: counts 0..CLK_DIV-1 and wraps. A tick occurs on the edge where the divider wraps to 0. clkDiv is high for exactly the clk following each tick edge. With CLK_DIV=1, clkDiv stays high continuously. The first tick occurs CLK_DIV clocks after reset release.
- On each tick: hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments; vcount wraps from V_TOTAL-1 to 0. Outputs load from the new counter values on the same edge, so they are stable for CLK_DIV clocks.
- column = hcount. row = vcount[8:0] if vcount<V_ACTIVE, else 0.
- displayActive = (hcount<H_ACTIVE) && (vcount<V_ACTIVE).
- hsync = SYNC_ACTIVE when H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC (656..751), else inverted.
- vsync = SYNC_ACTIVE when V_ACTIVE+V_FRONT <= vcount < V_ACTIVE+V_FRONT+V_SYNC (490..491), else inverted. vsync changes only on ticks where hcount wraps to 0.
- lineStart = 1 for the one clk after a tick that sets hcount=0; otherwise 0. frameStart likewise, requiring hcount=0 and vcount=0.
- Consequently, the first tick after reset yields column=0, row=0, displayActive=1, lineStart=1, frameStart=1.
- rst is asynchronous and takes priority at any point, including mid-line or during a sync pulse. enable low mid-frame forces the reset state on the next posedge; the scan restarts from frame start after enable returns high.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert rst mid-frame → all outputs immediately at reset values (hsync=vsync=1 at default polarity). Release rst → clkDiv first high 2 clks later with column=0, row=0, displayActive=1, frameStart=1, lineStart=1.
- Pixel strobe: free-run 20 clks at CLK_DIV=2 → clkDiv alternates 0/1, and column increments by 1 every 2 clks. Repeat at CLK_DIV=1 → clkDiv constant 1, column increments every clk.
- Horizontal timing: observe one line → displayActive high for 640 ticks (column 0..639) then low. hsync low exactly for column 656..751 (96 ticks). Column wraps 799→0 with lineStart=1, and row increments.
- Vertical timing: run a full frame → row reaches 479, then reads 0 while displayActive stays low for 45 lines. vsync low for lines 490..491 only. After line 524, frameStart=1 with row=0. Frame length = 800*525*2 = 840000 clks.
- Enable: drop enable at column=300, row=100 → next clk all outputs are at reset values and stay there. Raise enable → frameStart occurs 2 clks later.
- Polarity: SYNC_ACTIVE=1 build → hsync/vsync idle low and pulse high over the same column/line ranges.
